// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t   : per-source operand bypass select (regfile, EX/MEM, MEM/WB)
//   stage_ent_t : tracked control state of one E/M/W pipeline stage
package pipe_pkg;

    // The struct cannot follow the REG_AW parameter, so destinations are held
    // at this fixed width and zero-extended. REG_AW must not exceed it.
    localparam int unsigned STG_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXM = 2'b01,
        FWD_MWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [STG_DST_W-1:0] dst;
        logic                 is_load;
    } stage_ent_t;

endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one decode-stage source operand against the E, M and W entries.
// Ports:
//   dec_valid, src_used, src_addr : decode instruction valid, read enable, address
//   e_ent, m_ent, w_ent           : tracked stage entries
//   match_e/m/w                   : source reads the register that stage will write
//   load_use                      : source matches a load sitting in E
//   m_load_due                    : source matches a load sitting in M
module hazard_src_cmp
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 4
)(
    input  logic              dec_valid,
    input  logic              src_used,
    input  logic [REG_AW-1:0] src_addr,
    input  stage_ent_t        e_ent,
    input  stage_ent_t        m_ent,
    input  stage_ent_t        w_ent,
    output logic              match_e,
    output logic              match_m,
    output logic              match_w,
    output logic              load_use,
    output logic              m_load_due
);

    logic [STG_DST_W-1:0] src_ext;
    logic                 rd;
    logic                 unused_w_load;

    function automatic logic ent_hit(input stage_ent_t ent, input logic [STG_DST_W-1:0] addr);
        return ent.valid && ent.wr_en && (ent.dst == addr);
    endfunction

    assign src_ext = STG_DST_W'(src_addr);
    assign rd      = dec_valid & src_used;

    assign match_e = rd & ent_hit(e_ent, src_ext);
    assign match_m = rd & ent_hit(m_ent, src_ext);
    assign match_w = rd & ent_hit(w_ent, src_ext);

    assign load_use   = match_e & e_ent.is_load;
    assign m_load_due = match_m & m_ent.is_load;

    // The W-stage load flag has no bearing on hazards: data is already in hand.
    assign unused_w_load = w_ent.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and stage tracking for a 5-stage pipe.
// Ports:
//   clk, reset (sync, active-low)
//   dec_*            : decode-stage instruction (sources, destination, type)
//   br_taken_e       : branch resolved taken in execute -> flush fetch/decode
//   ext_stall        : global freeze; holds every tracked stage and the counter
//   stall_fd/flush_fd/bubble_de : pipeline register controls
//   fwd_sel          : 2 bits per source, 00 regfile, 01 EX/MEM, 10 MEM/WB
//   e/m/w_valid      : stage occupancy
//   wb_wr_en, wb_dst : register-file write port
//   hz_stall_cnt     : saturating count of hazard-stall cycles
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned FWD_EN  = 1
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic [NUM_SRC*REG_AW-1:0] dec_src_addr,
    input  logic [NUM_SRC-1:0]        dec_src_used,
    input  logic [REG_AW-1:0]         dec_dst_addr,
    input  logic                      dec_wr_en,
    input  logic                      dec_is_load,
    input  logic                      br_taken_e,
    input  logic                      ext_stall,
    output logic                      stall_fd,
    output logic                      flush_fd,
    output logic                      bubble_de,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      e_valid,
    output logic                      m_valid,
    output logic                      w_valid,
    output logic                      wb_wr_en,
    output logic [REG_AW-1:0]         wb_dst,
    output logic [15:0]               hz_stall_cnt
);

    stage_ent_t         e_q, m_q, w_q;
    stage_ent_t         dec_ent;
    logic [NUM_SRC-1:0] hit_e, hit_m, hit_w, ld_use, m_ld_due;
    logic               hz_stall;
    logic               hz_cnt_inc;

    assign dec_ent = '{valid:   dec_valid,
                       wr_en:   dec_wr_en,
                       dst:     STG_DST_W'(dec_dst_addr),
                       is_load: dec_is_load};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .dec_valid  (dec_valid),
            .src_used   (dec_src_used[i]),
            .src_addr   (dec_src_addr[i*REG_AW +: REG_AW]),
            .e_ent      (e_q),
            .m_ent      (m_q),
            .w_ent      (w_q),
            .match_e    (hit_e[i]),
            .match_m    (hit_m[i]),
            .match_w    (hit_w[i]),
            .load_use   (ld_use[i]),
            .m_load_due (m_ld_due[i])
        );
    end

    // Without bypass paths every in-flight producer is a hazard; with them only
    // a load in E is, since its data does not exist until the end of M.
    assign hz_stall = (FWD_EN != 0) ? |ld_use : |{hit_e, hit_m, hit_w};

    always_comb begin
        stall_fd   = 1'b0;
        flush_fd   = 1'b0;
        bubble_de  = 1'b0;
        hz_cnt_inc = 1'b0;
        fwd_sel    = '0;
        if (reset) begin
            if (ext_stall) begin
                stall_fd = 1'b1;
            end else if (br_taken_e) begin
                flush_fd  = 1'b1;
                bubble_de = 1'b1;
            end else if (hz_stall) begin
                stall_fd   = 1'b1;
                bubble_de  = 1'b1;
                hz_cnt_inc = 1'b1;
            end
            if ((FWD_EN != 0) && !stall_fd && dec_valid) begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    // Youngest producer wins.
                    if (hit_e[i] && !e_q.is_load) begin
                        fwd_sel[i*2 +: 2] = FWD_EXM;
                    end else if (hit_m[i] || m_ld_due[i]) begin
                        fwd_sel[i*2 +: 2] = FWD_MWB;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q          <= '0;
            m_q          <= '0;
            w_q          <= '0;
            hz_stall_cnt <= '0;
        end else if (!ext_stall) begin
            w_q <= m_q;
            m_q <= e_q;
            e_q <= bubble_de ? '0 : dec_ent;
            if (hz_cnt_inc && (hz_stall_cnt != 16'hFFFF)) begin
                hz_stall_cnt <= hz_stall_cnt + 16'd1;
            end
        end
    end

    assign e_valid  = e_q.valid;
    assign m_valid  = m_q.valid;
    assign w_valid  = w_q.valid;
    assign wb_wr_en = reset & w_q.valid & w_q.wr_en;
    assign wb_dst   = w_q.dst[REG_AW-1:0];

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 3, source operands per instruction (1..4).
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forward, 0 = stall on every RAW hazard.
REQ-004 SHALL have ports:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-low
  dec_valid  in  1  decode-stage instruction valid
  dec_src_addr  in  NUM_SRC*REG_AW  source register addresses, source i at [i*REG_AW +: REG_AW]
  dec_src_used  in  NUM_SRC  per-source read enable
  dec_dst_addr  in  REG_AW  destination register
  dec_wr_en  in  1  decode instruction writes a register
  dec_is_load  in  1  decode instruction is a load
  br_taken_e  in  1  branch resolved taken in execute
  ext_stall  in  1  global freeze, e.g. memory wait
  stall_fd  out  1  hold PC and fetch/decode register
  flush_fd  out  1  squash fetch/decode register contents
  bubble_de  out  1  load zero control into decode/execute register
  fwd_sel  out  NUM_SRC*2  per source: 00 regfile, 01 from EX/MEM, 10 from MEM/WB
  e_valid, m_valid, w_valid  out  1 each  stage-occupancy flags
  wb_wr_en  out  1  register-file write enable
  wb_dst  out  REG_AW  register-file write address
  hz_stall_cnt  out  16  saturating count of hazard-stall cycles

Function
REQ-005 SHALL track E, M and W entries, each {valid, wr_en, dst, is_load}, in registers.
REQ-006 Advance when ext_stall=0 on each edge: W<=M, M<=E, E<=decode entry; if bubble_de=1, E<=all-zero.
REQ-007 When ext_stall=1, SHALL hold all entries and the counter, with stall_fd=1, bubble_de=0, flush_fd=0.
REQ-008 Source i SHALL match stage X when dec_valid, dec_src_used[i], X.valid, X.wr_en are all 1 and dec_src_addr[i]==X.dst.
REQ-009 Load-use hazard SHALL be any source matching E with E.is_load=1; response: stall_fd=1, bubble_de=1.
REQ-010 With FWD_EN=0, any source match on E, M or W SHALL cause stall_fd=1, bubble_de=1.
REQ-011 With FWD_EN=1, fwd_sel[i] SHALL be:
  01 if source i matches E and E.is_load=0;
  else 10 if it matches M, or M-stage load data is due;
  else 11 never; 00 otherwise.
  E takes priority over M (youngest wins).
REQ-012 fwd_sel SHALL be 00 for all sources whenever FWD_EN=0, stall_fd=1 or dec_valid=0.
REQ-013 When br_taken_e=1 and ext_stall=0: flush_fd=1, bubble_de=1, stall_fd=0; this overrides any decode hazard.
REQ-014 Priority SHALL be ext_stall > br_taken_e > hazard stall > normal advance.
REQ-015 wb_wr_en SHALL equal W.valid & W.wr_en; wb_dst SHALL equal W.dst.
REQ-016 hz_stall_cnt SHALL increment on each cycle with a REQ-009/010 stall and ext_stall=0, saturating at 16'hFFFF.
REQ-017 Control outputs SHALL be combinational from registered state and inputs, with zero-cycle latency.
REQ-018 Load-use stall SHALL last exactly one cycle; the next cycle forwards 10 from the load in M.

Reset
REQ-019 On a clk edge with reset=0, SHALL clear all stage valid/wr_en/is_load/dst and hz_stall_cnt to 0.
REQ-020 During reset, stall_fd, flush_fd, bubble_de, wb_wr_en and fwd_sel SHALL be 0.
REQ-021 Reset asserted mid-stall or mid-flush SHALL discard all in-flight entries; first decode after release sees no hazard.

Structure
REQ-022 Package pipe_pkg SHALL hold the fwd_sel constants (FWD_RF=00, FWD_EXM=01, FWD_MWB=10) and the stage-entry struct typedef.
REQ-023 Sub-module hazard_src_cmp SHALL compare one source against E/M/W and return match flags; instantiate it NUM_SRC times via generate.

Verification
REQ-024 Bench SHALL cover these directed scenarios (defaults unless stated):
  ADD r3 then ADD r5 reading r3 -> fwd_sel[src]=01, stall_fd=0.
  LOAD r3 then use r3 -> one cycle stall_fd=1, bubble_de=1, hz_stall_cnt=1; next cycle fwd_sel=10.
  FWD_EN=0: ADD r3, then use r3 -> stall_fd=1 for 3 cycles, then fwd_sel=00.
  br_taken_e=1 with a simultaneous load-use hazard -> flush_fd=1, bubble_de=1, stall_fd=0, counter unchanged.
  ext_stall=1 for 4 cycles with LOAD in M -> entries frozen; afterwards wb_wr_en=1, wb_dst=load dst.
  Force 65536 hazard stalls -> hz_stall_cnt holds at 16'hFFFF.
  Reset pulse during a stall -> all outputs 0 next cycle.
